// File: rtl/fifo_rd_streamer.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream, grouping beats
// into bursts of BURST_LEN and flushing a short burst after TIMEOUT idle cycles.
module fifo_rd_streamer #(
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(BURST_LEN),
  parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rden,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_empty,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] BEAT_FINAL = CNT_W'(BURST_LEN - 1);
  localparam logic [TO_W-1:0]  IDLE_MAX   = TO_W'(TIMEOUT);

  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  beat_cnt;
  logic [TO_W-1:0]   idle_cnt;

  logic out_free;
  logic final_beat;
  logic idle_expired;
  logic move;
  logic move_last;

  function automatic logic [TO_W-1:0] idle_sat_inc(input logic [TO_W-1:0] cnt);
    return (cnt == IDLE_MAX) ? cnt : cnt + TO_W'(1);
  endfunction

  assign out_free     = !o_valid || i_ready;
  assign final_beat   = (beat_cnt == BEAT_FINAL);
  assign idle_expired = (idle_cnt == IDLE_MAX);

  // The held word only leaves once its successor is visible, because only then
  // do we know whether it must carry last.
  assign move      = hold_vld && out_free && (!i_empty || final_beat || idle_expired);
  assign move_last = final_beat || (idle_expired && i_empty);

  assign o_rden = !rst && !i_empty && (!hold_vld || move);
  assign o_busy = hold_vld || o_valid;

  // Hold stage: lookahead word popped from the FIFO
  always_ff @(posedge clk) begin
    if (o_rden) begin
      hold_data <= i_rddata;
    end
  end

  // Output stage and burst/idle bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (o_rden) begin
        hold_vld <= 1'b1;
      end else if (move) begin
        hold_vld <= 1'b0;
      end

      if (move) begin
        o_valid <= 1'b1;
        o_data  <= hold_data;
        o_last  <= move_last;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (move) begin
        beat_cnt <= move_last ? '0 : beat_cnt + CNT_W'(1);
      end

      // A newly arriving word restarts the count, cancelling any pending flush.
      if (move || o_rden) begin
        idle_cnt <= '0;
      end else if (hold_vld && i_empty) begin
        idle_cnt <= idle_sat_inc(idle_cnt);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FWFT FIFO on the read side.
module tb_fifo_rd_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_rden;
  logic [3:0] i_rddata;
  logic       i_empty;
  logic       o_valid;
  logic [3:0] o_data;
  logic       o_last;
  logic       i_ready;
  logic       o_busy;

  logic [3:0] mem [0:63];
  logic [5:0] wp = 6'd0;
  logic [5:0] rp = 6'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign i_empty  = (wp == rp);
  assign i_rddata = mem[rp];

  always @(posedge clk) begin
    if (o_rden) rp <= rp + 6'd1;
  end

  fifo_rd_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .o_rden   (o_rden),
    .i_rddata (i_rddata),
    .i_empty  (i_empty),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  task push(input logic [3:0] v);
    mem[wp] = v;
    wp = wp + 6'd1;
  endtask

  task test_reset();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({o_rden, o_valid, o_last, o_busy, o_data} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state rden/valid/last/busy/data got=%b exp=%b",
               {o_rden, o_valid, o_last, o_busy, o_data}, 8'h00);
    end
    push(4'h7);
    #1;
    total++;
    if (o_rden !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_pop got=%b exp=0", o_rden);
    end
    // j=0 is the first cycle out of reset; the lone word flushes at j=18
    for (int j = 0; j <= 19; j++) begin
      @(negedge clk);
      if (j == 0) rst = 1'b0;
      #1;
      e_rden = (j == 0);
      e_val  = (j == 18);
      e_busy = (j >= 1 && j <= 18);
      e_data = 4'h7;
      e_last = 1'b1;
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL reset_flush_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL reset_flush_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_full_bursts();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 0) for (int k = 1; k <= 8; k++) push(4'(k));
      #1;
      e_rden = (j <= 7);
      e_val  = (j >= 2 && j <= 9);
      e_busy = (j >= 1 && j <= 9);
      e_data = 4'(j - 1);
      e_last = (j == 5 || j == 9);
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL full_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL full_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_short_burst_timeout();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    for (int j = 0; j <= 23; j++) begin
      @(negedge clk);
      if (j == 0) for (int k = 1; k <= 5; k++) push(4'(k));
      #1;
      e_rden = (j <= 4);
      e_val  = (j >= 2 && j <= 5) || (j == 22);
      e_busy = (j >= 1 && j <= 22);
      e_data = (j == 22) ? 4'h5 : 4'(j - 1);
      e_last = (j == 5 || j == 22);
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL short_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL short_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_late_word();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    for (int j = 0; j <= 31; j++) begin
      @(negedge clk);
      if (j == 0) begin
        push(4'hA);
        push(4'hB);
      end
      if (j == 12) push(4'hC);
      #1;
      e_rden = (j == 0 || j == 1 || j == 12);
      e_val  = (j == 2 || j == 13 || j == 30);
      e_busy = (j >= 1 && j <= 30);
      e_data = (j == 2) ? 4'hA : (j == 13) ? 4'hB : 4'hC;
      e_last = (j == 30);
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL late_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL late_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_backpressure();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    for (int j = 0; j <= 29; j++) begin
      @(negedge clk);
      if (j == 0) for (int k = 1; k <= 6; k++) push(4'(k));
      if (j == 2) i_ready = 1'b0;
      if (j == 7) i_ready = 1'b1;
      #1;
      e_rden = (j <= 1) || (j >= 7 && j <= 10);
      e_val  = (j >= 2 && j <= 11) || (j == 28);
      e_busy = (j >= 1 && j <= 28);
      if (j <= 7)       e_data = 4'h1;
      else if (j == 28) e_data = 4'h6;
      else              e_data = 4'(j - 6);
      e_last = (j == 10 || j == 28);
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL bp_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL bp_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_reset_mid_burst();
    logic e_rden, e_val, e_busy, e_last;
    logic [3:0] e_data;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j == 0) for (int k = 1; k <= 3; k++) push(4'(k));
      if (j == 4) rst = 1'b1;
      if (j == 5) rst = 1'b0;
      if (j == 6) for (int k = 9; k <= 12; k++) push(4'(k));
      #1;
      e_rden = (j <= 2) || (j >= 6 && j <= 9);
      e_val  = (j == 2 || j == 3) || (j >= 8 && j <= 11);
      e_busy = (j >= 1 && j <= 4) || (j >= 7 && j <= 11);
      e_data = (j <= 3) ? 4'(j - 1) : 4'(j + 1);
      e_last = (j == 11);
      total++;
      if ({o_rden, o_valid, o_busy} !== {e_rden, e_val, e_busy}) begin
        bad++;
        $display("FAIL rstmid_ctl j=%0d rden/valid/busy got=%b exp=%b",
                 j, {o_rden, o_valid, o_busy}, {e_rden, e_val, e_busy});
      end
      if (j == 5) begin
        total++;
        if ({o_data, o_last} !== 5'h00) begin
          bad++;
          $display("FAIL rstmid_cleared data/last got=%h/%b exp=0/0", o_data, o_last);
        end
      end
      if (e_val) begin
        total++;
        if ({o_data, o_last} !== {e_data, e_last}) begin
          bad++;
          $display("FAIL rstmid_beat j=%0d data/last got=%h/%b exp=%h/%b",
                   j, o_data, o_last, e_data, e_last);
        end
      end
    end
  endtask

  task test_idle();
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      #1;
      total++;
      if ({i_empty, o_rden, o_valid, o_busy} !== 4'b1000) begin
        bad++;
        $display("FAIL idle j=%0d empty/rden/valid/busy got=%b exp=1000",
                 j, {i_empty, o_rden, o_valid, o_busy});
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_ready = 1'b1;
    test_reset();
    test_full_bursts();
    test_short_burst_timeout();
    test_late_word();
    test_backpressure();
    test_reset_mid_burst();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
